// File: rtl/line_buf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// line_buf_pingpong_ctrl
//
// Purpose:
//   Ping-pong line buffer controller for two external simple-dual-port RAM
//   banks (DEPTH = 2**ADDR_WIDTH words each). The controller writes the
//   incoming line into one bank and reads the previous line from the other
//   bank. At the end of every line it swaps the two banks. Downstream 2-row
//   filters receive the current pixel and the previous-line pixel of the same
//   column, aligned in time.
//
// Ports:
//   clk           single clock for this block and both RAM banks
//   rst_n         asynchronous, active-low reset
//   vs_in         frame sync; a rising edge starts a new frame
//   de_in         pixel valid, high for the run of pixels in one line
//   pix_in        input pixel
//   ram_wr_en     per-bank write enable (bit b drives bank b)
//   ram_wr_addr   shared write address
//   ram_wr_data   shared write data
//   ram_rd_addr   shared read address
//   ram_rd_data0  bank 0 read data
//   ram_rd_data1  bank 1 read data
//   pix_vld       output pixel valid
//   cur_pix       current-line pixel
//   prev_pix      previous-line pixel in the same column (0 when not valid)
//   prev_vld      prev_pix holds real data
//   wr_bank       bank currently being written
//   line_len      pixel count of the last completed line, saturates at DEPTH
//   ovf_err       sticky flag: a line was longer than DEPTH pixels
//
// Build option:
//   LBUF_RAM_OREG_EN  Define this macro when the RAM banks are built with
//                     their output register enabled (read latency 2). The
//                     output pipeline then gets one more stage, and the
//                     total latency grows from 2 cycles to 3 cycles.
// ---------------------------------------------------------------------------
module line_buf_pingpong_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vs_in,
  input  logic                  de_in,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [1:0]            ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data0,
  input  logic [DATA_WIDTH-1:0] ram_rd_data1,
  output logic                  pix_vld,
  output logic [DATA_WIDTH-1:0] cur_pix,
  output logic [DATA_WIDTH-1:0] prev_pix,
  output logic                  prev_vld,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH:0]   line_len,
  output logic                  ovf_err
);

  // The column counter is one bit wider than a RAM address. This lets it
  // represent DEPTH, the saturated "past the end of the RAM" value.
  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]   COL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                state_reg;
  logic                  vs_d_reg;
  logic                  de_d_reg;
  logic [DATA_WIDTH-1:0] pix_d_reg;
  logic [CW-1:0]         col_reg;
  logic                  skip_reg;
  logic                  wr_bank_reg;
  logic [CW-1:0]         line_len_reg;
  logic                  ovf_reg;

  // Stage 2 output registers
  logic                  vld_s2_reg;
  logic [DATA_WIDTH-1:0] cur_s2_reg;
  logic                  pvld_s2_reg;
  logic                  sel_s2_reg;

  // ---------------------------------------------------------------------
  // Stage 1 decode
  // ---------------------------------------------------------------------
  logic          vs_rise;
  logic          line_owned;
  logic          in_range;
  logic          wr_fire;
  logic          eol;
  logic          prev_ok;
  logic [CW-1:0] col_next;
  logic [CW-1:0] line_cnt;

  assign vs_rise = vs_in & ~vs_d_reg;

  // A pixel in stage 1 belongs to a buffered line only when all of these
  // hold: the controller has seen a frame sync, and the line was not cut
  // short by a frame sync in the middle of the line.
  assign line_owned = de_d_reg & ~skip_reg & (state_reg != ST_IDLE);

  // Addresses 0..DEPTH-1 fit in the RAM. The counter's top bit marks overflow.
  assign in_range = ~col_reg[ADDR_WIDTH];
  assign wr_fire  = line_owned & in_range;

  // De_d is about to fall. At this edge the final pixel leaves stage 1.
  assign eol = line_owned & ~de_in;

  // The previous line holds real data at this column only in RUN mode,
  // and only when that previous line reached this column.
  assign prev_ok = line_owned & (state_reg == ST_RUN) & (col_reg < line_len_reg);

  // Pixel count of the line that is ending, including the pixel in stage 1.
  // When the counter has saturated, the line was longer than DEPTH.
  assign line_cnt = in_range ? (col_reg + COL_ONE) : DEPTH;

  // The column is the index of the pixel that stage 1 will hold next cycle.
  // The first pixel of a line (de_in rising) starts the count at 0.
  always_comb begin
    col_next = '0;
    if (de_in && de_d_reg) begin
      col_next = in_range ? (col_reg + COL_ONE) : col_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM, input stage, and stage 2 pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      vs_d_reg     <= 1'b0;
      de_d_reg     <= 1'b0;
      pix_d_reg    <= '0;
      col_reg      <= '0;
      skip_reg     <= 1'b0;
      wr_bank_reg  <= 1'b0;
      line_len_reg <= '0;
      ovf_reg      <= 1'b0;
      vld_s2_reg   <= 1'b0;
      cur_s2_reg   <= '0;
      pvld_s2_reg  <= 1'b0;
      sel_s2_reg   <= 1'b0;
    end else begin
      vs_d_reg  <= vs_in;
      de_d_reg  <= de_in;
      pix_d_reg <= pix_in;

      // Stage 2 captures the pixel that is in stage 1, together with the
      // bank being read for it. The RAM returns that column's data at the
      // same edge.
      vld_s2_reg  <= de_d_reg;
      cur_s2_reg  <= pix_d_reg;
      pvld_s2_reg <= prev_ok;
      sel_s2_reg  <= ~wr_bank_reg;

      if (vs_rise) begin
        state_reg    <= ST_FIRST;
        wr_bank_reg  <= 1'b0;
        col_reg      <= '0;
        line_len_reg <= '0;
        ovf_reg      <= 1'b0;
        // A sync that arrives in the middle of a line throws away the rest
        // of that line: no writes, no bank swap, no line_len update.
        // A sync that arrives together with the first pixel keeps the line.
        skip_reg     <= de_in & de_d_reg;
      end else begin
        col_reg <= col_next;

        if (!de_in) begin
          skip_reg <= 1'b0;
        end

        if (line_owned && !in_range) begin
          ovf_reg <= 1'b1;
        end

        if (eol) begin
          line_len_reg <= line_cnt;
          wr_bank_reg  <= ~wr_bank_reg;
          if (state_reg == ST_FIRST) begin
            state_reg <= ST_RUN;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional extra stage for RAM banks that have an output register
  // ---------------------------------------------------------------------
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_cur;
  logic                  out_pvld;
  logic                  out_sel;

`ifdef LBUF_RAM_OREG_EN
  logic                  vld_s3_reg;
  logic [DATA_WIDTH-1:0] cur_s3_reg;
  logic                  pvld_s3_reg;
  logic                  sel_s3_reg;

  // Read data arrives one cycle later. Delay everything that must stay
  // aligned with that data by one more cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s3_reg  <= 1'b0;
      cur_s3_reg  <= '0;
      pvld_s3_reg <= 1'b0;
      sel_s3_reg  <= 1'b0;
    end else begin
      vld_s3_reg  <= vld_s2_reg;
      cur_s3_reg  <= cur_s2_reg;
      pvld_s3_reg <= pvld_s2_reg;
      sel_s3_reg  <= sel_s2_reg;
    end
  end

  assign out_vld  = vld_s3_reg;
  assign out_cur  = cur_s3_reg;
  assign out_pvld = pvld_s3_reg;
  assign out_sel  = sel_s3_reg;
`else
  assign out_vld  = vld_s2_reg;
  assign out_cur  = cur_s2_reg;
  assign out_pvld = pvld_s2_reg;
  assign out_sel  = sel_s2_reg;
`endif

  // ---------------------------------------------------------------------
  // RAM interface
  // ---------------------------------------------------------------------
  // The write enables come straight from registers through gates. Because
  // of this, an asynchronous reset removes them at once.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_we
      localparam logic BANK = 1'(gi);
      assign ram_wr_en[gi] = wr_fire & (wr_bank_reg == BANK);
    end
  endgenerate

  assign ram_wr_addr = col_reg[ADDR_WIDTH-1:0];
  assign ram_wr_data = pix_d_reg;
  assign ram_rd_addr = col_reg[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_data;

  assign rd_data  = out_sel ? ram_rd_data1 : ram_rd_data0;

  assign pix_vld  = out_vld;
  assign cur_pix  = out_cur;
  assign prev_vld = out_pvld;
  assign prev_pix = out_pvld ? rd_data : '0;

  assign wr_bank  = wr_bank_reg;
  assign line_len = line_len_reg;
  assign ovf_err  = ovf_reg;

endmodule

// File: tb/tb_line_buf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buf_pingpong_ctrl
//
// Self-checking bench for line_buf_pingpong_ctrl. Two behavioural RAM banks
// sit around the DUT. The reference model works at the line level: it keeps
// the last completed line, that line's length, the mode, the bank, and the
// overflow flag. From these it predicts every output pixel and the per-line
// write counts. Lines use random pixel values and random lengths, and are
// mixed with frame syncs, overflow lines, mid-line syncs and mid-line resets.
// Define LBUF_RAM_OREG_EN for both the bench and the DUT to test the
// registered-output RAM build.
// ---------------------------------------------------------------------------
module tb_line_buf_pingpong_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam int GAP   = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vs_in;
  logic          de_in;
  logic [DW-1:0] pix_in;
  logic [1:0]    ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data0;
  logic [DW-1:0] ram_rd_data1;
  logic          pix_vld;
  logic [DW-1:0] cur_pix;
  logic [DW-1:0] prev_pix;
  logic          prev_vld;
  logic          wr_bank;
  logic [AW:0]   line_len;
  logic          ovf_err;

  always #5 clk = ~clk;

  line_buf_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vs_in        (vs_in),
    .de_in        (de_in),
    .pix_in       (pix_in),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data0 (ram_rd_data0),
    .ram_rd_data1 (ram_rd_data1),
    .pix_vld      (pix_vld),
    .cur_pix      (cur_pix),
    .prev_pix     (prev_pix),
    .prev_vld     (prev_vld),
    .wr_bank      (wr_bank),
    .line_len     (line_len),
    .ovf_err      (ovf_err)
  );

  // ---------------- behavioural RAM banks + write counters ----------------
  logic [DW-1:0] mem0 [0:DEPTH-1];
  logic [DW-1:0] mem1 [0:DEPTH-1];
  logic [DW-1:0] q0, q1;
  int            wr_cnt0 = 0;
  int            wr_cnt1 = 0;

  always @(posedge clk) begin
    if (ram_wr_en[0]) mem0[ram_wr_addr] <= ram_wr_data;
    if (ram_wr_en[1]) mem1[ram_wr_addr] <= ram_wr_data;
    q0 <= mem0[ram_rd_addr];
    q1 <= mem1[ram_rd_addr];
    wr_cnt0 <= wr_cnt0 + int'(ram_wr_en[0]);
    wr_cnt1 <= wr_cnt1 + int'(ram_wr_en[1]);
  end

`ifdef LBUF_RAM_OREG_EN
  localparam int LAT = 3;
  logic [DW-1:0] q0_r, q1_r;
  always @(posedge clk) begin
    q0_r <= q0;
    q1_r <= q1;
  end
  assign ram_rd_data0 = q0_r;
  assign ram_rd_data1 = q1_r;
`else
  localparam int LAT = 2;
  assign ram_rd_data0 = q0;
  assign ram_rd_data1 = q1;
`endif

  // ---------------- reference model state ----------------
  typedef struct {
    int            cyc;
    logic [DW-1:0] cur;
    logic          pv;
    logic [DW-1:0] pp;
    logic          dc;   // previous-line fields not predictable (line cut by sync)
  } exp_t;

  exp_t          exp_q[$];
  int            m_mode;      // 0 = idle, 1 = first line of frame, 2 = running
  logic          m_bank;
  int            m_prev_len;
  logic          m_ovf;
  logic [DW-1:0] prev_line [0:DEPTH-1];
  logic [DW-1:0] line_pix  [0:2199];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (pix_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pix_vld", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc, e.cyc);
        check("cur_pix", cur_pix, e.cur);
        if (!e.dc) begin
          check("prev_vld", prev_vld, e.pv);
          check("prev_pix", prev_pix, e.pp);
        end
      end
    end else begin
      check("quiet_prev", {prev_vld, prev_pix}, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic model_sync();
    m_mode     = 1;
    m_bank     = 1'b0;
    m_prev_len = 0;
    m_ovf      = 1'b0;
  endtask

  task automatic check_status(input string where);
    check({where, "_line_len"}, line_len, m_prev_len);
    check({where, "_wr_bank"}, wr_bank, m_bank);
    check({where, "_ovf_err"}, ovf_err, m_ovf);
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    step();
    step();
    vs_in = 1'b0;
    step();
    model_sync();
    check_status("vs");
  endtask

  // base >= 0: pixels base, base+1, ...; otherwise random.
  // vs_at / rst_at >= 0: raise vs / pulse rst_n at that pixel index.
  task automatic send_line(input int len, input int base, input int vs_at, input int rst_at);
    int   snap0, snap1, exp_w, n;
    logic aborted;
    exp_t e;
    snap0   = wr_cnt0;
    snap1   = wr_cnt1;
    aborted = 1'b0;
    for (int i = 0; i < len; i++) begin
      line_pix[i] = (base >= 0) ? DW'(base + i) : DW'($urandom_range(0, 255));
      if (i == vs_at) begin
        vs_in = 1'b1;
        model_sync();
        aborted = 1'b1;
      end
      if (vs_at >= 0 && i == vs_at + 2) vs_in = 1'b0;
      de_in  = 1'b1;
      pix_in = line_pix[i];
      e.cyc = cyc + LAT;
      e.cur = line_pix[i];
      e.dc  = aborted;
      e.pv  = (m_mode == 2) && (i < m_prev_len);
      e.pp  = e.pv ? prev_line[i] : '0;
      exp_q.push_back(e);
      step();
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", {pix_vld, prev_vld, ram_wr_en, wr_bank, ovf_err}, 0);
        check("rst_cur_pix", cur_pix, 0);
        check("rst_prev_pix", prev_pix, 0);
        check("rst_line_len", line_len, 0);
        check("rst_addr", {ram_wr_addr, ram_rd_addr}, 0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        m_mode     = 0;
        m_bank     = 1'b0;
        m_prev_len = 0;
        m_ovf      = 1'b0;
        aborted    = 1'b1;
      end
    end
    de_in = 1'b0;
    vs_in = 1'b0;
    for (int g = 0; g < GAP; g++) step();
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    if (!aborted) begin
      n     = (len > DEPTH) ? DEPTH : len;
      exp_w = (m_mode != 0) ? n : 0;
      check("wr_cnt_bank0", wr_cnt0 - snap0, (m_bank == 1'b0) ? exp_w : 0);
      check("wr_cnt_bank1", wr_cnt1 - snap1, (m_bank == 1'b1) ? exp_w : 0);
      if (m_mode != 0) begin
        for (int k = 0; k < n; k++) prev_line[k] = line_pix[k];
        m_prev_len = n;
        m_bank     = ~m_bank;
        if (len > DEPTH) m_ovf = 1'b1;
        if (m_mode == 1) m_mode = 2;
      end
    end
    check_status("eol");
    $display("line len=%0d vs_at=%0d rst_at=%0d -> line_len=%0d wr_bank=%0d ovf_err=%0d",
             len, vs_at, rst_at, line_len, wr_bank, ovf_err);
  endtask

  initial begin
    rst_n  = 1'b0;
    vs_in  = 1'b0;
    de_in  = 1'b0;
    pix_in = '0;
    m_mode = 0; m_bank = 1'b0; m_prev_len = 0; m_ovf = 1'b0;
    step();
    step();
    check("reset_flags", {pix_vld, prev_vld, ram_wr_en, wr_bank, ovf_err}, 0);
    check("reset_cur_pix", cur_pix, 0);
    check("reset_line_len", line_len, 0);
    rst_n = 1'b1;
    step();

    send_line(5, -1, -1, -1);          // IDLE: pass-through, no writes
    vs_pulse();
    send_line(4, 'h10, -1, -1);        // first line of the frame
    send_line(4, 'hA0, -1, -1);        // previous line = 0x10..0x13
    send_line(6, -1, -1, -1);          // longer than the previous line
    for (int r = 0; r < 8; r++) send_line($urandom_range(1, 40), -1, -1, -1);
    send_line(DEPTH, -1, -1, -1);      // exactly full
    send_line(2100, -1, -1, -1);       // overflow
    send_line(10, -1, -1, -1);
    vs_pulse();                        // clears ovf_err
    send_line(8, -1, -1, -1);
    send_line(9, -1, -1, -1);
    send_line(12, -1, 3, -1);          // sync at column 3 while running
    send_line(7, -1, -1, -1);
    send_line(7, -1, -1, -1);
    send_line(10, -1, -1, 5);          // reset in the middle of a line
    send_line(6, -1, -1, -1);          // IDLE again: no writes
    vs_pulse();
    send_line(5, -1, -1, -1);
    send_line($urandom_range(1, 30), -1, -1, -1);
    send_line($urandom_range(1, 30), -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_buf_pingpong_ctrl.md
Name: line_buf_pingpong_ctrl

Overview:
- Single-clock ping-pong controller for two external 2048x8 simple-dual-port RAM banks. The RAM instances sit outside this block, one wr/rd port pair per bank, both clocked by clk.
- Sits in the video pipeline after capture/scaler. Writes the current line into one bank while reading the previous line from the other, then swaps banks at end of line.
- Delivers column-aligned current and previous-line pixels to downstream 2-row filters.

Parameters:
- DATA_WIDTH, 8, pixel and RAM data width.
- ADDR_WIDTH, 11, RAM address width; line capacity DEPTH = 2**ADDR_WIDTH = 2048.

Ports:
- clk  in  1  single clock for the block and both RAM banks.
- rst_n  in  1  reset, asynchronous and active-low.
- vs_in  in  1  frame sync, active high; a rising edge starts a frame.
- de_in  in  1  pixel valid; high for one line's run of pixels.
- pix_in  in  DATA_WIDTH  input pixel.
- ram_wr_en  out  2  per-bank write enable; bit b drives bank b.
- ram_wr_addr  out  ADDR_WIDTH  shared write address.
- ram_wr_data  out  DATA_WIDTH  shared write data.
- ram_rd_addr  out  ADDR_WIDTH  shared read address.
- ram_rd_data0  in  DATA_WIDTH  bank 0 read data.
- ram_rd_data1  in  DATA_WIDTH  bank 1 read data.
- pix_vld  out  1  output pixel valid.
- cur_pix  out  DATA_WIDTH  current-line pixel.
- prev_pix  out  DATA_WIDTH  previous-line pixel, same column.
- prev_vld  out  1  prev_pix holds real data.
- wr_bank  out  1  bank currently being written.
- line_len  out  ADDR_WIDTH+1  pixel count of the last completed line, saturating at DEPTH.
- ovf_err  out  1  sticky: a line exceeded DEPTH pixels.

Behaviour:
- Reset values: all outputs 0; state IDLE; column counter 0.
- Stage 1 (registered input):
  - de_d, pix_d, col registered; col counts 0,1,2,… while de_in is high.
  - When de_d=1 and col<DEPTH: ram_wr_en[wr_bank]=1, ram_wr_addr=col, ram_wr_data=pix_d, ram_rd_addr=col.
  - Read data is taken from bank ~wr_bank.
- Stage 2: pix_vld=de_d delayed 1; cur_pix=pix_d delayed 1; prev_pix=read data of bank ~wr_bank as captured at stage 1.
- Latency: de_in/pix_in to pix_vld/cur_pix is exactly 2 cycles (RAM read latency 1).
- prev_vld = pix_vld AND state==RUN AND col(at stage 1) < line_len. When prev_vld=0, prev_pix is forced to 0.
- End of line (de_d falling):
  - line_len<=min(col_count, DEPTH); wr_bank toggles; col clears.
  - FIRST->RUN.
  - Zero-length lines (de never high) do not toggle the bank.
- vs_in rising edge, any state and including mid-line:
  - Go to FIRST; wr_bank<=0; col<=0; line_len<=0; ovf_err<=0.
  - A partially written line is discarded and the bank does not toggle.
- FSM:
  - IDLE: pixels pass to cur_pix/pix_vld; no RAM writes; prev_vld=0. Leaves on first vs rising edge.
  - FIRST: writes enabled; prev_vld=0.
  - RUN: write and read both active.
- Overflow: col>=DEPTH suppresses the write; ovf_err<=1, sticky until the next vs or reset. cur_pix still passes; prev_vld=0 for those columns. col saturates at DEPTH.
- A previous line shorter than the current line gives prev_vld=0 for columns >= line_len.
- rst_n low mid-line: immediate clear to reset values; ram_wr_en goes 0 asynchronously.
- Read/write address collision: none, since the two banks are always distinct.

Optional Feature:
- Macro LBUF_RAM_OREG_EN.
  - Defined: RAM banks are built with output register enabled (read latency 2). Controller inserts one extra delay on pix_vld, cur_pix, prev_vld and the bank-select for read data. Total latency 3 cycles.
  - Undefined: read latency 1, total latency 2 cycles as above.

Test Plan:
- Reset, vs pulse, then line 0 of 4 pixels 0x10,0x11,0x12,0x13 -> pix_vld high 4 cycles starting 2 cycles after de_in; cur_pix matches input; prev_vld=0; bank0 addr0-3 written; line_len=4; wr_bank=1.
- Line 1 of 4 pixels 0xA0-0xA3 -> prev_pix=0x10-0x13 aligned with cur_pix=0xA0-0xA3; prev_vld=1 all 4; writes go to bank1; wr_bank returns to 0.
- Line of 2100 pixels after a 2048-pixel line -> ovf_err=1; no writes at col 2048-2099; prev_vld=0 for those columns; line_len=2048; next vs clears ovf_err.
- Line 6 pixels after a 4-pixel line -> prev_vld=1,1,1,1,0,0; prev_pix=0 on the last two.
- vs rising at column 3 of a line in RUN -> state FIRST, wr_bank=0, next line has prev_vld=0, line_len=0.
- rst_n low mid-line for 1 cycle -> all outputs 0 immediately; subsequent de_in ignored for RAM writes until vs (state IDLE).
